// File: rtl/srambank_ctrl_256x4x74_if.sv
// Request/response handshake bundle between a client (master) and the bank controller (slave).
`timescale 1ns/1ps
interface srambank_ctrl_256x4x74_if #(
    parameter int AW = 10,
    parameter int DW = 74
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/srambank_ctrl_256x4x74.sv
// In-order request queue and pin driver for srambank_256x4x74_6t122; returns read data
// on a valid/ready response channel three cycles after an uncontended accept.
`timescale 1ns/1ps
module srambank_ctrl_256x4x74 #(
    parameter int AW     = 10,
    parameter int DW     = 74,
    parameter int QDEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    srambank_ctrl_256x4x74_if.slave bus,
    output logic [AW-1:0]          ADDRESS,
    output logic [DW-1:0]          wd,
    output logic                   banksel,
    output logic                   read,
    output logic                   write,
    input  logic [DW-1:0]          dataout,
    output logic                   busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + AW + DW;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    logic [EW-1:0] fifo_mem [QDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_en_q;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic          rd_s2_q, rd_s2_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic          req_ready_w;
    logic          push;
    logic          issue;
    logic [EW-1:0] head;
    logic          head_write;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;

    // ready_en_q keeps req_ready low until the first edge after reset release
    assign req_ready_w = ready_en_q & (count_q < QDEPTH_C);
    assign push        = bus.req_valid & req_ready_w;

    assign head       = fifo_mem[rd_ptr_q];
    assign head_write = head[EW-1];
    assign head_addr  = head[AW+DW-1:DW];
    assign head_wdata = head[DW-1:0];

    // A read may only go out once the previous read has left the pipeline and its
    // response slot is free (or being freed this edge); writes never wait.
    assign issue = (count_q != '0) &
                   (head_write | (~read_q & ~rd_s2_q & (~rsp_valid_q | bus.rsp_ready)));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.req_write, bus.req_addr, bus.req_wdata};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        address_d   = address_q;
        wd_d        = wd_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        rd_s2_d     = read_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (issue) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            address_d = head_addr;
            read_d    = ~head_write;
            write_d   = head_write;
            if (head_write) begin
                wd_d = head_wdata;
            end
        end
        if (push && !issue) begin
            count_d = count_q + CW'(1);
        end else if (!push && issue) begin
            count_d = count_q - CW'(1);
        end

        if (rd_s2_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = dataout;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            address_q   <= '0;
            wd_q        <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_en_q  <= 1'b1;
            address_q   <= address_d;
            wd_q        <= wd_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rd_s2_q     <= rd_s2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    assign ADDRESS = address_q;
    assign wd      = wd_q;
    assign read    = read_q;
    assign write   = write_q;
    assign banksel = read_q | write_q;
    assign busy    = (count_q != '0) | read_q | write_q | rd_s2_q | rsp_valid_q;
endmodule

// File: tb/tb_srambank_ctrl_256x4x74.sv
// Bench for srambank_ctrl_256x4x74 with a behavioural bank model and a read-data scoreboard.
`timescale 1ns/1ps
module tb_srambank_ctrl_256x4x74;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  bank_addr;
    logic [73:0] bank_wd;
    logic [73:0] bank_dout = '0;
    logic        bank_sel, bank_rd, bank_wr, busy;

    logic [73:0] bank_mem [1024];
    logic [73:0] shadow   [1024];
    logic [73:0] exp_q [$];
    int          waddr_q [$];
    int          wcyc_q  [$];
    int          rcyc_q  [$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    srambank_ctrl_256x4x74_if #(.AW(10), .DW(74)) bus ();

    srambank_ctrl_256x4x74 #(.AW(10), .DW(74), .QDEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .ADDRESS (bank_addr),
        .wd      (bank_wd),
        .banksel (bank_sel),
        .read    (bank_rd),
        .write   (bank_wr),
        .dataout (bank_dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Bank model: samples pins at the rising edge, read data appears the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bank_sel && bank_wr) bank_mem[bank_addr] <= bank_wd;
        if (bank_sel && bank_rd) bank_dout <= bank_mem[bank_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin log and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (bank_wr) begin
            waddr_q.push_back(int'(bank_addr));
            wcyc_q.push_back(cyc);
        end
        if (bank_rd) rcyc_q.push_back(cyc);
        if (bank_sel || bank_rd || bank_wr) begin
            chk("rw_excl", {127'd0, bank_rd & bank_wr}, 128'd0);
            chk("banksel_eq", {127'd0, bank_sel}, {127'd0, bank_rd | bank_wr});
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            chk("rsp_expected", {127'd0, exp_q.size() != 0}, 128'd1);
            if (exp_q.size() != 0) chk("rsp_data", {54'd0, bus.rsp_data}, {54'd0, exp_q.pop_front()});
        end
    end

    task automatic send(input logic w, input logic [9:0] a, input logic [73:0] d, output int stalls);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        stalls = 0;
        while (!bus.req_ready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        chk("req_accept", {127'd0, stalls < 50}, 128'd1);
        @(posedge clk); #1;
        if (w) shadow[a] = d;
        else exp_q.push_back(shadow[a]);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!bus.rsp_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid_wait", {127'd0, bus.rsp_valid}, 128'd1);
    endtask

    initial begin
        int st, tot, n;
        logic [73:0] d0, dx, da, db;
        d0 = 74'h2_AAAA_5555_0000_FFFF;
        dx = 74'h1_2345_6789_ABCD_EF01;
        da = 74'h0_0F0F_F0F0_1111_2222;
        db = 74'h3_DEAD_BEEF_CAFE_0042;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {127'd0, bus.req_ready}, 128'd0);
        chk("rst_rsp_valid", {127'd0, bus.rsp_valid}, 128'd0);
        chk("rst_rsp_data", {54'd0, bus.rsp_data}, 128'd0);
        chk("rst_address", {118'd0, bank_addr}, 128'd0);
        chk("rst_wd", {54'd0, bank_wd}, 128'd0);
        chk("rst_pins", {125'd0, bank_sel, bank_rd, bank_wr}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", {127'd0, bus.req_ready}, 128'd1);
        chk("idle_busy", {127'd0, busy}, 128'd0);

        // Write to the top address, then read it back with latency check
        send(1'b1, 10'h3FF, d0, st);
        chk("wr_busy", {127'd0, busy}, 128'd1);
        @(posedge clk); #1;
        chk("wr_pins", {125'd0, bank_sel, bank_rd, bank_wr}, 128'b101);
        chk("wr_address", {118'd0, bank_addr}, 128'h3FF);
        chk("wr_wd", {54'd0, bank_wd}, {54'd0, d0});
        send(1'b0, 10'h3FF, '0, st);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_latency", 128'(n), 128'd3);
        chk("rd_data_3ff", {54'd0, bus.rsp_data}, {54'd0, d0});
        wait_drain();

        // Four back-to-back writes, req_valid held
        waddr_q.delete(); wcyc_q.delete();
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 10'(i), 74'(i + 16), st);
            tot += st;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_stalls", 128'(tot), 128'd0);
        chk("b2b_count", 128'(waddr_q.size()), 128'd4);
        if (waddr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_addr", 128'(waddr_q[i]), 128'(i));
                chk("b2b_cycle", 128'(wcyc_q[i]), 128'(wcyc_q[0] + i));
            end
        end

        // Read 5 held un-accepted for 6 cycles with read 6 queued behind it
        send(1'b1, 10'd5, da, st);
        send(1'b1, 10'd6, db, st);
        repeat (3) @(posedge clk);
        #1;
        rcyc_q.delete();
        bus.rsp_ready = 1'b0;
        send(1'b0, 10'd5, '0, st);
        send(1'b0, 10'd6, '0, st);
        wait_rsp_valid();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {127'd0, bus.rsp_valid}, 128'd1);
            chk("hold_data", {54'd0, bus.rsp_data}, {54'd0, da});
        end
        chk("hold_rd_pulses", 128'(rcyc_q.size()), 128'd1);
        bus.rsp_ready = 1'b1;
        wait_drain();
        chk("after_rd_pulses", 128'(rcyc_q.size()), 128'd2);

        // Read-after-write to the same address
        waddr_q.delete(); wcyc_q.delete(); rcyc_q.delete();
        send(1'b1, 10'd7, dx, st);
        send(1'b0, 10'd7, '0, st);
        wait_drain();
        chk("raw_wr_seen", 128'(wcyc_q.size()), 128'd1);
        chk("raw_rd_seen", 128'(rcyc_q.size()), 128'd1);
        if (wcyc_q.size() != 0 && rcyc_q.size() != 0)
            chk("raw_order", {127'd0, wcyc_q[0] < rcyc_q[0]}, 128'd1);

        // Reset while a write is on the pins and a response is pending
        send(1'b1, 10'd9, da, st);
        repeat (3) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        send(1'b0, 10'd5, '0, st);
        wait_rsp_valid();
        send(1'b1, 10'd9, db, st);
        @(posedge clk); #1;
        chk("pre_rst_write", {127'd0, bank_wr}, 128'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_write", {127'd0, bank_wr}, 128'd0);
        chk("arst_rsp_valid", {127'd0, bus.rsp_valid}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_req_ready", {127'd0, bus.req_ready}, 128'd0);
        exp_q.delete();
        shadow[9] = da;
        bus.rsp_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_pulse", {125'd0, bank_sel, bank_rd, bank_wr}, 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {126'd0, busy, bank_sel}, 128'd0);
        send(1'b0, 10'd9, '0, st);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
